// File: rtl/otbn_pq_pkg.sv
// Shared PQ ALU types: plane-unit operation bundle plus the Keccak plane sequencer enums.
package otbn_pq_pkg;
  localparam int PQLEN        = 32;
  localparam int KeccakPlanes = 5;
  localparam int KeccakLaneW  = 64;

  typedef enum logic {
    KeccakPlaneTheta = 1'b0,
    KeccakPlaneChi   = 1'b1
  } keccak_plane_op_e;

  typedef struct packed {
    keccak_plane_op_e        op;
    logic [PQLEN*8-1:0]      operand_a;
    logic [PQLEN*8-1:0]      operand_b;
  } keccak_plane_operation_t;

  typedef enum logic {
    KeccakSeqTheta = 1'b0,
    KeccakSeqChi   = 1'b1
  } keccak_seq_cmd_e;

  typedef enum logic [2:0] {
    Idle, Parity, DCalc, Apply, Chi, Done
  } keccak_seq_state_e;
endpackage

// File: rtl/keccak_plane_unit.sv
// Combinational Keccak plane unit: THETA D-column from parities, or CHI on one plane.
module keccak_plane_unit
  import otbn_pq_pkg::*;
(
  input  keccak_plane_operation_t operation_i,
  output logic [PQLEN*8-1:0]      rs0_o,
  output logic [PQLEN*8-1:0]      rs1_o
);
  logic [KeccakPlanes-1:0][KeccakLaneW-1:0] in_l, out_l;

  always_comb begin
    in_l  = {operation_i.operand_b[KeccakLaneW-1:0], operation_i.operand_a};
    out_l = '0;
    for (int x = 0; x < KeccakPlanes; x++) begin
      if (operation_i.op == KeccakPlaneChi) begin
        out_l[x] = in_l[x] ^ (~in_l[(x + 1) % 5] & in_l[(x + 2) % 5]);
      end else begin
        // D[x] = C[x-1] ^ rotl(C[x+1], 1)
        out_l[x] = in_l[(x + 4) % 5] ^
                   {in_l[(x + 1) % 5][KeccakLaneW-2:0], in_l[(x + 1) % 5][KeccakLaneW-1]};
      end
    end
  end

  assign rs0_o = out_l[3:0];
  assign rs1_o = {{(PQLEN*8-KeccakLaneW){1'b0}}, out_l[4]};
endmodule

// File: rtl/keccak_plane_sequencer.sv
// Holds the 1600-bit Keccak state and walks it plane-by-plane through the shared plane unit.
module keccak_plane_sequencer
  import otbn_pq_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           cmd_i,
  output logic                           busy_o,
  output logic                           done_o,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [2:0]                     wr_idx_i,
  input  logic [KeccakPlanes*KeccakLaneW-1:0] wr_plane_i,
  input  logic [2:0]                     rd_idx_i,
  output logic [KeccakPlanes*KeccakLaneW-1:0] rd_plane_o,
  output logic                           err_o,
  output keccak_plane_operation_t        operation_o,
  input  logic [PQLEN*8-1:0]             rs0_i,
  input  logic [PQLEN*8-1:0]             rs1_i
);
  typedef logic [KeccakPlanes-1:0][KeccakLaneW-1:0] plane_t;

  keccak_seq_state_e           state_q, state_d;
  plane_t [KeccakPlanes-1:0]   plane_q, plane_d;
  plane_t                      c_q, c_d, d_q, d_d, res;
  logic [2:0]                  y_q, y_d;
  logic                        err_q, err_d;
  logic                        unused_rs1;

  assign unused_rs1 = ^rs1_i[PQLEN*8-1:KeccakLaneW];
  assign res        = {rs1_i[KeccakLaneW-1:0], rs0_i};

  assign busy_o     = (state_q != Idle);
  assign done_o     = (state_q == Done);
  assign wr_ready_o = ~busy_o;
  assign err_o      = err_q;
  assign rd_plane_o = (rd_idx_i < 3'(KeccakPlanes)) ? plane_q[rd_idx_i] : '0;

  always_comb begin
    state_d     = state_q;
    plane_d     = plane_q;
    c_d         = c_q;
    d_d         = d_q;
    y_d         = y_q;
    err_d       = 1'b0;
    operation_o = '0;
    unique case (state_q)
      Idle: begin
        if (wr_valid_i) begin
          if (wr_idx_i < 3'(KeccakPlanes)) plane_d[wr_idx_i] = wr_plane_i;
          else                             err_d = 1'b1;
        end
        if (start_i) begin
          y_d     = '0;
          c_d     = '0;
          state_d = (keccak_seq_cmd_e'(cmd_i) == KeccakSeqChi) ? Chi : Parity;
        end
      end
      Parity: begin
        c_d = c_q ^ plane_q[y_q];
        y_d = y_q + 3'd1;
        if (y_q == 3'd4) begin
          y_d     = '0;
          state_d = DCalc;
        end
      end
      DCalc: begin
        operation_o.op        = KeccakPlaneTheta;
        operation_o.operand_a = c_q[3:0];
        operation_o.operand_b = {{(PQLEN*8-KeccakLaneW){1'b0}}, c_q[4]};
        d_d                   = res;
        state_d               = Apply;
      end
      Apply: begin
        plane_d[y_q] = plane_q[y_q] ^ d_q;
        y_d          = y_q + 3'd1;
        if (y_q == 3'd4) begin
          y_d     = '0;
          state_d = Done;
        end
      end
      Chi: begin
        operation_o.op        = KeccakPlaneChi;
        operation_o.operand_a = plane_q[y_q][3:0];
        operation_o.operand_b = {{(PQLEN*8-KeccakLaneW){1'b0}}, plane_q[y_q][4]};
        plane_d[y_q]          = res;
        y_d                   = y_q + 3'd1;
        if (y_q == 3'd4) begin
          y_d     = '0;
          state_d = Done;
        end
      end
      Done:    state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      plane_q <= '0;
      c_q     <= '0;
      d_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      c_q     <= c_d;
      d_q     <= d_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_keccak_plane_sequencer.sv
// Directed bench: sequencer driving a keccak_plane_unit responder, hand-computed expectations.
module tb_keccak_plane_sequencer;
  import otbn_pq_pkg::*;

  localparam int CW = $bits(keccak_plane_operation_t);

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cmd = 1'b0, wr_valid = 1'b0;
  logic busy, done, wr_ready, err;
  logic [2:0] wr_idx = '0, rd_idx = '0;
  logic [319:0] wr_plane = '0, rd_plane;
  keccak_plane_operation_t op, e;
  logic [PQLEN*8-1:0] rs0, rs1;
  int checks = 0, failures = 0;
  int ndone, at;

  always #5 clk = ~clk;

  keccak_plane_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cmd_i(cmd),
    .busy_o(busy), .done_o(done), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_idx_i(wr_idx), .wr_plane_i(wr_plane), .rd_idx_i(rd_idx), .rd_plane_o(rd_plane),
    .err_o(err), .operation_o(op), .rs0_i(rs0), .rs1_i(rs1)
  );

  keccak_plane_unit u_unit (.operation_i(op), .rs0_o(rs0), .rs1_o(rs1));

  function automatic logic [319:0] mk(input logic [63:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_plane(input string tag, input int y, input logic [319:0] exp);
    rd_idx = 3'(y);
    #1;
    chk($sformatf("%s_p%0d", tag, y), CW'(rd_plane), CW'(exp));
  endtask

  task automatic wr(input int idx, input logic [319:0] p);
    wr_valid = 1'b1;
    wr_idx   = 3'(idx);
    wr_plane = p;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic go(input logic c);
    start = 1'b1;
    cmd   = c;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", CW'(busy), CW'(1'b0));
    chk("rst_done", CW'(done), CW'(1'b0));
    chk("rst_err", CW'(err), CW'(1'b0));
    chk("rst_op", CW'(op), CW'(0));
    for (int y = 0; y < 5; y++) chk_plane("rst", y, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // 2: CHI on {1,2,4,8,16} in every plane
    for (int y = 0; y < 5; y++) wr(y, mk(1, 2, 4, 8, 16));
    go(1'b1);
    e = '0;
    e.op = KeccakPlaneChi;
    e.operand_a = {64'd8, 64'd4, 64'd2, 64'd1};
    e.operand_b = {192'b0, 64'd16};
    chk("chi_op_y0", CW'(op), CW'(e));
    chk("chi_wr_ready", CW'(wr_ready), CW'(1'b0));
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("chi_done_c%0d", k), CW'(done), CW'(k == 6));
      tick();
    end
    chk("chi_idle", CW'(busy), CW'(1'b0));
    for (int y = 0; y < 5; y++) chk_plane("chi", y, mk(5, 10, 20, 9, 18));
    tick();

    // 3: THETA with a single set bit
    wr(0, mk(1, 0, 0, 0, 0));
    for (int y = 1; y < 5; y++) wr(y, '0);
    go(1'b0);
    e = '0;
    e.op = KeccakPlaneTheta;
    e.operand_a = 256'd1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) chk("theta_op_parity", CW'(op), CW'(0));
      if (k == 6) chk("theta_op_dcalc", CW'(op), CW'(e));
      chk($sformatf("theta_done_c%0d", k), CW'(done), CW'(k == 12));
      tick();
    end
    chk_plane("theta", 0, mk(1, 1, 0, 0, 2));
    for (int y = 1; y < 5; y++) chk_plane("theta", y, mk(0, 1, 0, 0, 2));
    tick();

    // 4: write and restart attempts while busy are dropped
    wr(0, mk(1, 0, 0, 0, 0));
    for (int y = 1; y < 5; y++) wr(y, '0);
    go(1'b0);
    tick();
    start = 1'b1; cmd = 1'b1;
    wr_valid = 1'b1; wr_idx = 3'd2; wr_plane = '1;
    chk("busy_wr_ready", CW'(wr_ready), CW'(1'b0));
    chk("busy_busy", CW'(busy), CW'(1'b1));
    tick();
    tick();
    start = 1'b0; wr_valid = 1'b0;
    ndone = 0; at = 0;
    for (int k = 4; k <= 30; k++) begin
      if (done) begin ndone++; at = k; end
      tick();
    end
    chk("busy_ndone", CW'(ndone), CW'(1));
    chk("busy_done_at", CW'(at), CW'(12));
    chk_plane("busy", 0, mk(1, 1, 0, 0, 2));
    for (int y = 1; y < 5; y++) chk_plane("busy", y, mk(0, 1, 0, 0, 2));
    tick();

    // 5: reset in the third APPLY cycle
    go(1'b0);
    repeat (8) tick();
    chk("midrst_busy_before", CW'(busy), CW'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", CW'(busy), CW'(1'b0));
    chk("midrst_done", CW'(done), CW'(1'b0));
    for (int y = 0; y < 5; y++) chk_plane("midrst", y, '0);
    tick();
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("midrst_no_done", CW'(ndone), CW'(0));

    // 6: out-of-range index
    wr(3, mk(64'hDEADBEEF00000001, 64'h0123456789ABCDEF, 64'h8000000000000000, 64'h5A5A, 64'hFFFF0000FFFF0000));
    chk("bad_err_before", CW'(err), CW'(1'b0));
    wr(5, '1);
    chk("bad_err_pulse", CW'(err), CW'(1'b1));
    tick();
    chk("bad_err_clear", CW'(err), CW'(1'b0));
    for (int y = 0; y < 5; y++)
      chk_plane("bad", y, (y == 3) ? mk(64'hDEADBEEF00000001, 64'h0123456789ABCDEF,
                                        64'h8000000000000000, 64'h5A5A, 64'hFFFF0000FFFF0000) : '0);
    chk_plane("bad_rd", 5, '0);
    chk_plane("bad_rd", 7, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
